// File: rtl/trigger_pulser.sv
// ---------------------------------------------------------------------------
// trigger_pulser
//
// Turns single-cycle trigger requests into clean pulses on a board trigger
// line. Each pulse stays high for at least N cycles and is followed by a low
// gap of at least N cycles, so an N-stage debouncer at the far end of the
// link passes every pulse.
//
// Parameters:
//   N  minimum pulse width and minimum gap, in cycles (1 .. 2^W-1)
//   W  width of the width/holdoff registers and of the drop counter
//
// Ports:
//   aclk         clock, rising edge
//   areset       asynchronous, active-high reset
//   enable       when low, new requests are ignored (and not counted)
//   trig_in      pulse request, one cycle per request
//   width_reg    requested high time in cycles (clamped up to N)
//   holdoff_reg  requested low gap after each pulse in cycles (clamped up to N)
//   dout         registered trigger line
//   busy         high while a pulse or its holdoff gap is in progress
//   drop_cnt     count of rejected requests, saturating at all-ones
//
// Build option:
//   TRIGGER_PULSER_QUEUE_EN  adds a one-deep pending request. A request that
//   arrives while busy is held and issued back-to-back when the holdoff gap
//   ends. Without it, every request arriving while busy is dropped and counted.
// ---------------------------------------------------------------------------
module trigger_pulser #(
    parameter int N = 10,
    parameter int W = 16
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         enable,
    input  logic         trig_in,
    input  logic [W-1:0] width_reg,
    input  logic [W-1:0] holdoff_reg,
    output logic         dout,
    output logic         busy,
    output logic [W-1:0] drop_cnt
);

    localparam logic [W-1:0] NMIN = W'(N);
    localparam logic [W-1:0] ONE  = W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLDOFF
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   heff_q, heff_d;
    logic [W-1:0]   drop_q, drop_d;
    logic           dout_q, dout_d;
    logic [W-1:0]   weff_new, heff_new;
    logic           busy_now;
    logic           hold_done;
    logic           drop_req;
`ifdef TRIGGER_PULSER_QUEUE_EN
    logic           pend_q, pend_d;
`endif

    // Effective lengths for a request accepted this cycle. Only the holdoff
    // length needs its own register: the width goes straight into the counter.
    always_comb begin
        weff_new = (width_reg   < NMIN) ? NMIN : width_reg;
        heff_new = (holdoff_reg < NMIN) ? NMIN : holdoff_reg;
    end

    // Next-state logic. The counter is loaded with length-1 and the state
    // moves on when it reaches zero, so each phase lasts exactly its length.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        heff_d    = heff_q;
        dout_d    = dout_q;
        drop_d    = drop_q;
        drop_req  = 1'b0;
        busy_now  = (state_q != IDLE);
        hold_done = (state_q == HOLDOFF) && (cnt_q == '0);
`ifdef TRIGGER_PULSER_QUEUE_EN
        pend_d    = pend_q;
`endif

        case (state_q)
            IDLE: begin
                if (trig_in && enable) begin
                    state_d = PULSE;
                    cnt_d   = weff_new - ONE;
                    heff_d  = heff_new;
                    dout_d  = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLDOFF;
                    cnt_d   = heff_q - ONE;
                    dout_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef TRIGGER_PULSER_QUEUE_EN
                    // A held request (or one arriving on this very cycle)
                    // starts straight away with fresh lengths; enable low
                    // here cancels it silently.
                    if (enable && (pend_q || trig_in)) begin
                        state_d = PULSE;
                        cnt_d   = weff_new - ONE;
                        heff_d  = heff_new;
                        dout_d  = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase

`ifdef TRIGGER_PULSER_QUEUE_EN
        // Requests while busy fill the single pending slot; once it is full
        // further requests are rejected. The slot empties when the gap ends.
        if (busy_now && trig_in && enable) begin
            if (pend_q) begin
                drop_req = 1'b1;
            end else if (!hold_done) begin
                pend_d = 1'b1;
            end
        end
        if (hold_done) begin
            pend_d = 1'b0;
        end
`else
        drop_req = busy_now && trig_in && enable;
`endif

        // Saturating drop counter.
        if (drop_req && (drop_q != '1)) begin
            drop_d = drop_q + ONE;
        end
    end

    // State register with asynchronous reset so the line drops immediately.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            heff_q  <= '0;
            drop_q  <= '0;
            dout_q  <= 1'b0;
`ifdef TRIGGER_PULSER_QUEUE_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            heff_q  <= heff_d;
            drop_q  <= drop_d;
            dout_q  <= dout_d;
`ifdef TRIGGER_PULSER_QUEUE_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign dout     = dout_q;
    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_trigger_pulser.sv
// ---------------------------------------------------------------------------
// tb_trigger_pulser
//
// Directed bench for trigger_pulser with N=10, W=16. Accepted requests push
// their expected (width, gap) onto a scoreboard queue; a monitor pops an entry
// whenever a pulse starts on dout and checks the measured high and low times.
// A small N-stage debouncer model listens to dout for the loopback scenario.
// Follows TRIGGER_PULSER_QUEUE_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_trigger_pulser;

    localparam int N = 10;
    localparam int W = 16;

    logic         aclk;
    logic         areset;
    logic         enable;
    logic         trig_in;
    logic [W-1:0] width_reg;
    logic [W-1:0] holdoff_reg;
    logic         dout;
    logic         busy;
    logic [W-1:0] drop_cnt;

    typedef struct {
        int w;
        int h;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   exp_drop = 0;
    int   hi_cnt = 0;
    int   lo_cnt = 0;
    logic in_hi = 1'b0;
    logic in_lo = 1'b0;
    int   pulses_seen = 0;

    logic [N-1:0] db_sr;
    logic         db_out;
    logic         db_prev = 1'b0;
    int           db_rises = 0;

    trigger_pulser #(.N(N), .W(W)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .enable      (enable),
        .trig_in     (trig_in),
        .width_reg   (width_reg),
        .holdoff_reg (holdoff_reg),
        .dout        (dout),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    // 10 ns clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // One comparison: counts it, and reports it if it does not hold.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge so they are stable at the next rise.
    task automatic applyStimulus(input logic t, input logic e);
        @(negedge aclk);
        trig_in = t;
        enable  = e;
    endtask

    function automatic int clampN(input int v);
        return (v < N) ? N : v;
    endfunction

    // Counts falling-edge samples with busy high, bounded.
    task automatic countBusy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge aclk);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            n++;
            @(negedge aclk);
        end
        checkOutput("idle_wait", busy, 0);
    endtask

    // Scoreboard monitor: measures every pulse and its following gap.
    always @(negedge aclk) begin
        if (areset) begin
            in_hi = 1'b0;
            in_lo = 1'b0;
        end else if (dout) begin
            if (in_lo) begin
                checkOutput("pulse_gap", lo_cnt, cur.h);
                in_lo = 1'b0;
            end
            if (!in_hi) begin
                in_hi  = 1'b1;
                hi_cnt = 0;
                pulses_seen++;
                checkOutput("pulse_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                end else begin
                    cur.w = -1;
                    cur.h = -1;
                end
            end
            hi_cnt++;
        end else begin
            if (in_hi) begin
                in_hi = 1'b0;
                checkOutput("pulse_width", hi_cnt, cur.w);
                in_lo  = 1'b1;
                lo_cnt = 0;
            end
            if (in_lo) begin
                if (busy) begin
                    lo_cnt++;
                end else begin
                    checkOutput("pulse_gap", lo_cnt, cur.h);
                    in_lo = 1'b0;
                end
            end
        end
    end

    // Receiving N-stage debouncer: output follows the line once N samples agree.
    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            db_sr  <= '0;
            db_out <= 1'b0;
        end else begin
            db_sr <= {db_sr[N-2:0], dout};
            if (&db_sr) begin
                db_out <= 1'b1;
            end else if (~|db_sr) begin
                db_out <= 1'b0;
            end
        end
    end

    always @(negedge aclk) begin
        if (db_out && !db_prev) begin
            db_rises++;
        end
        db_prev = db_out;
    end

    initial begin
        int n;
        int w;
        int h;
        int loops;
        int rises0;

        areset      = 1'b1;
        enable      = 1'b1;
        trig_in     = 1'b0;
        width_reg   = '0;
        holdoff_reg = '0;

        // Reset holds everything quiet even with requests toggling.
        $display("[TB] reset behaviour");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            #1;
            checkOutput("rst_dout", dout, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_drop", drop_cnt, 0);
            applyStimulus(1'b0, 1'b1);
        end
        @(negedge aclk);
        areset = 1'b0;

        // Short settings are clamped up to N.
        $display("[TB] clamped short pulse");
        width_reg   = 16'd3;
        holdoff_reg = 16'd5;
        exp_q.push_back('{w: 10, h: 10});
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("latency_dout", dout, 1);
        countBusy(n);
        checkOutput("busy_len_short", n, 20);
        applyStimulus(1'b0, 1'b1);

        // Long pulse; changing width mid-pulse has no effect.
        $display("[TB] long pulse");
        width_reg   = 16'd100;
        holdoff_reg = 16'd40;
        exp_q.push_back('{w: 100, h: 40});
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        width_reg = 16'd20;
        countBusy(n);
        checkOutput("busy_len_long", n, 140);
        applyStimulus(1'b0, 1'b1);

        // Requests at PULSE cycle 5 and on the final HOLDOFF cycle.
        $display("[TB] requests while busy");
        width_reg   = 16'd0;
        holdoff_reg = 16'd0;
        exp_q.push_back('{w: 10, h: 10});
`ifdef TRIGGER_PULSER_QUEUE_EN
        exp_q.push_back('{w: 10, h: 10});
        exp_drop = exp_drop + 1;
`else
        exp_drop = exp_drop + 2;
`endif
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        repeat (13) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("busy_final_hold", busy, 1);
        applyStimulus(1'b0, 1'b1);
        waitIdle(100);
        applyStimulus(1'b0, 1'b1);
        checkOutput("drop_busy_req", drop_cnt, exp_drop);
        checkOutput("queue_drained", exp_q.size(), 0);

        // Disabled requests are ignored and not counted.
        $display("[TB] enable gating");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0);
            checkOutput("gated_busy", busy, 0);
        end
        checkOutput("gated_drop", drop_cnt, exp_drop);

        // Enable falls mid-pulse: pulse and gap complete in full.
        width_reg   = 16'd15;
        holdoff_reg = 16'd12;
        exp_q.push_back('{w: 15, h: 12});
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        waitIdle(100);
        applyStimulus(1'b0, 1'b1);
        checkOutput("en_drop_mid_pulse_drop", drop_cnt, exp_drop);

        // Reset mid-pulse drops the line before the next clock edge.
        $display("[TB] reset mid-pulse");
        width_reg   = 16'd30;
        holdoff_reg = 16'd10;
        exp_q.push_back('{w: 30, h: 10});
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b1);
        checkOutput("pre_rst_dout", dout, 1);
        @(posedge aclk);
        #2;
        areset = 1'b1;
        #1;
        checkOutput("async_rst_dout", dout, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_drop", drop_cnt, 0);
        exp_q.delete();
        exp_drop = 0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;

        // Loopback through the debouncer with random legal lengths.
        $display("[TB] loopback");
        rises0 = db_rises;
        loops  = 8;
        for (int i = 0; i < loops; i++) begin
            w = $urandom_range(25, 10);
            h = $urandom_range(25, 10);
            width_reg   = W'(w);
            holdoff_reg = W'(h);
            exp_q.push_back('{w: clampN(w), h: clampN(h)});
            applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1);
            waitIdle(100);
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("loopback_pulses", db_rises - rises0, loops);
        checkOutput("loopback_db_low", db_out, 0);
        checkOutput("final_queue_empty", exp_q.size(), 0);
        checkOutput("final_drop", drop_cnt, exp_drop);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hang anywhere above.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/trigger_pulser.md
# trigger_pulser

- Generates clean, debounce-compatible digital pulses on an output trigger line from single-cycle internal trigger requests.
- It is the transmit end of the trigger links received by the team's N-stage debouncer. Every pulse and every gap after it is at least N cycles long, so a receiving debouncer with the same N passes each pulse.
- Sits between the timed-event logic (a request source) and the board output pin.

## Interface
Parameters:
- N, 10: minimum pulse width and minimum gap, in cycles. Matches the receiving debouncer's stage count. Legal range 1 to 2^W-1.
- W, 16: width of the width/holdoff registers and of the drop counter.

Ports:
- aclk  input  1  clock; all logic is on the rising edge.
- areset  input  1  asynchronous, active-high reset.
- enable  input  1  when low, new requests are ignored.
- trig_in  input  1  pulse request, one cycle per request.
- width_reg  input  W  requested high time, in cycles.
- holdoff_reg  input  W  requested low gap after each pulse, in cycles.
- dout  output  1  registered trigger line.
- busy  output  1  high while state is not IDLE.
- drop_cnt  output  W  count of rejected requests; saturates at 2^W-1.

## Operation
- FSM states: IDLE, PULSE, HOLDOFF.
- Effective lengths: Weff = max(width_reg, N); Heff = max(holdoff_reg, N). Both are latched when a request is accepted. Later changes to the registers do not affect a pulse already in progress.
- IDLE:
  - trig_in=1 and enable=1: latch Weff and Heff, load the counter, go to PULSE.
  - trig_in=1 and enable=0: ignored; drop_cnt is not incremented.
- PULSE:
  - dout=1.
  - After Weff cycles, go to HOLDOFF.
- HOLDOFF:
  - dout=0.
  - After Heff cycles, go to IDLE.
- Request while busy (PULSE or HOLDOFF, including the final HOLDOFF cycle) with enable=1: handled according to the Configuration section.
- enable falling mid-pulse: the current PULSE and HOLDOFF complete normally.
- Counter arithmetic:
  - Down-counter of W bits, loaded with (length − 1).
  - The state transition happens on count==0.
  - No wrap: the minimum length is N ≥ 1.
- drop_cnt:
  - +1 per rejected request.
  - Holds at all-ones once saturated.
  - Cleared only by reset.

## Timing
- Reset values, applied asynchronously: dout=0, busy=0, drop_cnt=0, state=IDLE, counter=0, pending flag=0.
- Reset asserted mid-pulse: dout drops to 0 immediately, without waiting for aclk.
- Latency: trig_in sampled high at edge k gives dout=1 and busy=1 after edge k, both registered (1 cycle).
- dout stays high for exactly Weff cycles, then low for exactly Heff cycles.
- busy falls at the same edge where state returns to IDLE, which is k + Weff + Heff.
- Minimum request-to-request spacing with no drops: Weff + Heff + 1 cycles.
- After areset deasserts, a request is accepted on the first rising edge.

## Configuration
- Macro: TRIGGER_PULSER_QUEUE_EN.
- Defined:
  - A one-deep pending register is added.
  - A request arriving while busy sets pending, provided pending is not already set; otherwise it is dropped and counted.
  - On leaving HOLDOFF with pending=1:
    - go directly to PULSE;
    - latch fresh Weff and Heff from the current register values;
    - clear pending.
  - The queued pulse starts 1 cycle after the previous HOLDOFF ends, so dout shows no extra IDLE cycle.
  - enable=0 at the moment pending is issued cancels the pending request; it is not counted.
- Undefined:
  - No pending register.
  - Every request arriving while busy is dropped and counted in drop_cnt.

## Test plan
All scenarios use N=10, W=16.

- Reset behaviour: areset=1 with trig_in toggling → dout=0, busy=0, drop_cnt=0 throughout. Assert areset mid-PULSE → dout=0 within the same cycle.
- Short width is clamped: width_reg=3, holdoff_reg=5, single trig_in → dout high 10 cycles, low 10 cycles, busy high 20 cycles.
- Long width: width_reg=100, holdoff_reg=40 → dout high exactly 100 cycles, busy high 140 cycles. Changing width_reg during the pulse has no effect on it.
- Request during PULSE (at cycle 5) and during the final HOLDOFF cycle:
  - Macro undefined: drop_cnt=2 and only one pulse appears.
  - Macro defined: a second pulse starts immediately after HOLDOFF and drop_cnt=1.
- Gating by enable:
  - enable=0 with 3 requests → no pulse and drop_cnt=0.
  - enable cleared mid-pulse → the pulse completes with full width.
- Loopback: dout feeds a debouncer with N=10 stages, with random Weff/Heff ≥ 10 → every pulse is reproduced on the debouncer output and none is lost.
